fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 52 +++++
 rtl/fetch_stage_if.sv | 36 +++
 rtl/fetch_align.sv | 57 +++++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the pipeline stages: instruction codes, ifun limits,
// status codes, fetch FSM states and the decoded-field bundle.
package fetch_stage_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] ICMOVQ  = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE        = 4'hF;
  localparam logic [3:0] OPQ_IFUN_MAX = 4'd3;
  // CMOVQ shares the condition encoding with JXX, hence the same limit.
  localparam logic [3:0] JXX_IFUN_MAX = 4'd6;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {RUN, HLT, ADR, INS} state_t;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        invalid;
  } fetch_fields_t;

  function automatic logic [2:0] stat_of(input state_t s);
    logic [2:0] r;
    r = SAOK;
    case (s)
      HLT:     r = SHLT;
      ADR:     r = SADR;
      INS:     r = SINS;
      default: r = SAOK;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: imem request/response, execute/memory feedback and decoded outputs.
// icount_o exists only when FETCH_ICOUNT_EN is defined.
interface fetch_stage_if;
  logic        step_i;
  logic [63:0] imem_addr_o;
  logic [79:0] imem_data_i;
  logic        imem_err_i;
  logic        cnd_i;
  logic [63:0] valM_i;
  logic [3:0]  icode_o;
  logic [3:0]  ifun_o;
  logic [3:0]  rA_o;
  logic [3:0]  rB_o;
  logic [63:0] valC_o;
  logic [63:0] valP_o;
  logic [2:0]  stat_o;
`ifdef FETCH_ICOUNT_EN
  logic [63:0] icount_o;
`endif

  modport slave (
    input  step_i, imem_data_i, imem_err_i, cnd_i, valM_i,
    output imem_addr_o, icode_o, ifun_o, rA_o, rB_o, valC_o, valP_o, stat_o
`ifdef FETCH_ICOUNT_EN
    , output icount_o
`endif
  );

  modport master (
    output step_i, imem_data_i, imem_err_i, cnd_i, valM_i,
    input  imem_addr_o, icode_o, ifun_o, rA_o, rB_o, valC_o, valP_o, stat_o
`ifdef FETCH_ICOUNT_EN
    , input icount_o
`endif
  );
endinterface

// File: rtl/fetch_align.sv
// Combinational split of the 10 fetched bytes into instruction fields, plus
// fall-through PC and the illegal-encoding flag.
module fetch_align
  import fetch_stage_pkg::*;
(
  input  logic [63:0]   pc,
  input  logic [79:0]   data,
  output fetch_fields_t fields
);

  logic [3:0] icode;
  logic [3:0] ifun;
  logic       need_regids;
  logic       need_valc;
  logic       invalid;

  assign icode = data[7:4];
  assign ifun  = data[3:0];

  always_comb begin
    need_regids = 1'b0;
    need_valc   = 1'b0;
    case (icode)
      ICMOVQ, IOPQ, IPUSHQ, IPOPQ: need_regids = 1'b1;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      IJXX, ICALL: need_valc = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    invalid = 1'b0;
    case (icode)
      IOPQ:         invalid = (ifun > OPQ_IFUN_MAX);
      IJXX, ICMOVQ: invalid = (ifun > JXX_IFUN_MAX);
      default:      invalid = (icode > IPOPQ) || (ifun != 4'h0);
    endcase
  end

  always_comb begin
    fields         = '0;
    fields.icode   = icode;
    fields.ifun    = ifun;
    fields.ra      = need_regids ? data[15:12] : RNONE;
    fields.rb      = need_regids ? data[11:8]  : RNONE;
    // The constant starts right after the register byte when one is present.
    if (need_valc) begin
      fields.valc  = need_regids ? data[79:16] : data[71:8];
    end
    fields.valp    = pc + 64'd1 + {63'd0, need_regids} + {60'd0, need_valc, 3'b000};
    fields.invalid = invalid;
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, RUN/HLT/ADR/INS status FSM and next-PC selection.
// Optional retired-instruction counter icount_o when FETCH_ICOUNT_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
)(
  input logic          clk_i,
  input logic          rst_n_i,
  fetch_stage_if.slave bus
);

  state_t        state;
  state_t        state_nxt;
  logic [63:0]   pc;
  logic [63:0]   pc_nxt;
  fetch_fields_t f;
  logic          squash;

  fetch_align u_align (
    .pc     (pc),
    .data   (bus.imem_data_i),
    .fields (f)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Faulting or halting leaves PC on the offending instruction.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (state == RUN && bus.step_i) begin
      if (bus.imem_err_i) begin
        state_nxt = ADR;
      end else if (f.invalid) begin
        state_nxt = INS;
      end else if (f.icode == IHALT) begin
        state_nxt = HLT;
      end else begin
        case (f.icode)
          ICALL:   pc_nxt = f.valc;
          IJXX:    pc_nxt = bus.cnd_i ? f.valc : f.valp;
          IRET:    pc_nxt = bus.valM_i;
          default: pc_nxt = f.valp;
        endcase
      end
    end
  end

`ifdef FETCH_ICOUNT_EN
  logic        accept;
  logic [63:0] icount;

  assign accept = (state == RUN) && bus.step_i && !bus.imem_err_i && !f.invalid;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      icount <= '0;
    end else if (accept) begin
      icount <= icount + 64'd1;
    end
  end

  assign bus.icount_o = icount;
`endif

  // Present a bubble downstream so no register write can be triggered.
  assign squash = (state != RUN) || bus.imem_err_i;

  assign bus.imem_addr_o = pc;
  assign bus.icode_o     = squash ? INOP  : f.icode;
  assign bus.ifun_o      = squash ? 4'h0  : f.ifun;
  assign bus.rA_o        = squash ? RNONE : f.ra;
  assign bus.rB_o        = squash ? RNONE : f.rb;
  assign bus.valC_o      = squash ? 64'h0 : f.valc;
  assign bus.valP_o      = f.valp;
  assign bus.stat_o      = stat_of(state);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an instruction-length-table reference model.
module tb_fetch_stage;

  localparam logic [63:0] RST_PC = 64'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ilen(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h3, 4'h4, 4'h5:       return 10;
      4'h7, 4'h8:             return 9;
      default:                return 1;
    endcase
  endfunction

  function automatic logic [3:0] fmax(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h7: return 4'd6;
      4'h6:       return 4'd3;
      default:    return 4'd0;
    endcase
  endfunction

  function automatic bit has_regs(input logic [79:0] d);
    return ilen(d[7:4]) == 2 || ilen(d[7:4]) == 10;
  endfunction

  function automatic logic [63:0] m_valc(input logic [79:0] d);
    if (ilen(d[7:4]) < 9) return 64'h0;
    return has_regs(d) ? d[79:16] : d[71:8];
  endfunction

  function automatic bit legal(input logic [79:0] d);
    return (d[7:4] <= 4'hB) && (d[3:0] <= fmax(d[7:4]));
  endfunction

  function automatic logic [63:0] target(input logic [63:0] pc, input logic [79:0] d,
                                         input bit cnd, input logic [63:0] vm);
    logic [63:0] fall;
    fall = pc + 64'(ilen(d[7:4]));
    case (d[7:4])
      4'h8:    return m_valc(d);
      4'h7:    return cnd ? m_valc(d) : fall;
      4'h9:    return vm;
      default: return fall;
    endcase
  endfunction

  logic [63:0] m_pc;
  logic [2:0]  m_stat;
`ifdef FETCH_ICOUNT_EN
  logic [63:0] m_cnt;
`endif

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc   <= RST_PC;
      m_stat <= 3'd1;
`ifdef FETCH_ICOUNT_EN
      m_cnt  <= 64'd0;
`endif
    end else if (m_stat == 3'd1 && bus.step_i) begin
      if (bus.imem_err_i) m_stat <= 3'd3;
      else if (!legal(bus.imem_data_i)) m_stat <= 3'd4;
      else begin
`ifdef FETCH_ICOUNT_EN
        m_cnt <= m_cnt + 64'd1;
`endif
        if (bus.imem_data_i[7:4] == 4'h0) m_stat <= 3'd2;
        else m_pc <= target(m_pc, bus.imem_data_i, bus.cnd_i, bus.valM_i);
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic        sq;
    logic [79:0] d;
    if (chk_on) begin
      d  = bus.imem_data_i;
      sq = (m_stat != 3'd1) || bus.imem_err_i;
      chk("addr",  bus.imem_addr_o, m_pc);
      chk("stat",  64'(bus.stat_o), 64'(m_stat));
      chk("icode", 64'(bus.icode_o), sq ? 64'h1 : 64'(d[7:4]));
      chk("ifun",  64'(bus.ifun_o),  sq ? 64'h0 : 64'(d[3:0]));
      chk("rA",    64'(bus.rA_o), (sq || !has_regs(d)) ? 64'hF : 64'(d[15:12]));
      chk("rB",    64'(bus.rB_o), (sq || !has_regs(d)) ? 64'hF : 64'(d[11:8]));
      chk("valC",  bus.valC_o, sq ? 64'h0 : m_valc(d));
      chk("valP",  bus.valP_o, m_pc + 64'(ilen(d[7:4])));
`ifdef FETCH_ICOUNT_EN
      chk("icount", bus.icount_o, m_cnt);
`endif
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [79:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [63:0] c, input bit regs);
    return regs ? {c, b1, b0} : {8'h00, c, b0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [79:0] d, input bit st, input bit cnd,
                       input bit err, input logic [63:0] vm);
    bus.imem_data_i = d;
    bus.step_i      = st;
    bus.cnd_i       = cnd;
    bus.imem_err_i  = err;
    bus.valM_i      = vm;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.step_i = 1'b1;
    cyc();
    rst_n = 1'b1;
  endtask

  logic [7:0] codes [10] = '{8'h27, 8'h77, 8'h11, 8'hC0, 8'h91, 8'h26, 8'h76, 8'h63, 8'h64, 8'hB1};
  logic [2:0] code_stat [10] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd1, 3'd1, 3'd1, 3'd4, 3'd4};

  initial begin
    drive(80'h0, 1'b0, 1'b0, 1'b0, 64'h0);
    repeat (2) cyc();
    rst_n  = 1'b1;
    chk_on = 1'b1;
    chk("rst_addr", bus.imem_addr_o, 64'h0);
    chk("rst_stat", 64'(bus.stat_o), 64'd1);

    // IRMOVQ decode and step
    drive(mk(8'h30, 8'hF3, 64'h10, 1'b1), 1'b1, 1'b0, 1'b0, 64'h0);
    #1;
    chk("irmov_icode", 64'(bus.icode_o), 64'h3);
    chk("irmov_rA",    64'(bus.rA_o), 64'hF);
    chk("irmov_rB",    64'(bus.rB_o), 64'h3);
    chk("irmov_valC",  bus.valC_o, 64'h10);
    chk("irmov_valP",  bus.valP_o, 64'hA);
    cyc();
    chk("irmov_pc", bus.imem_addr_o, 64'hA);

    drive(mk(8'h80, 8'h00, 64'h20, 1'b0), 1'b1, 1'b0, 1'b0, 64'h0);
    cyc();
    chk("call20_pc", bus.imem_addr_o, 64'h20);
    drive(mk(8'h70, 8'h00, 64'h100, 1'b0), 1'b1, 1'b0, 1'b0, 64'h0);
    #1;
    chk("jmp_valP", bus.valP_o, 64'h29);
    cyc();
    chk("jmp_nt_pc", bus.imem_addr_o, 64'h29);
    drive(mk(8'h73, 8'h00, 64'h20, 1'b0), 1'b1, 1'b1, 1'b0, 64'h0);
    cyc();
    chk("jxx_back_pc", bus.imem_addr_o, 64'h20);
    drive(mk(8'h70, 8'h00, 64'h100, 1'b0), 1'b1, 1'b1, 1'b0, 64'h0);
    cyc();
    chk("jmp_t_pc", bus.imem_addr_o, 64'h100);
    drive(mk(8'h90, 8'h00, 64'h0, 1'b0), 1'b1, 1'b0, 1'b0, 64'h48);
    cyc();
    chk("ret_pc", bus.imem_addr_o, 64'h48);
    drive(mk(8'h80, 8'h00, 64'h200, 1'b0), 1'b1, 1'b0, 1'b0, 64'h0);
    cyc();
    chk("call_pc", bus.imem_addr_o, 64'h200);

    // stall for three cycles, including a pending address error
    drive(mk(8'h10, 8'h00, 64'h0, 1'b0), 1'b0, 1'b0, 1'b0, 64'h0);
    cyc();
    drive(mk(8'h00, 8'h00, 64'h0, 1'b0), 1'b0, 1'b0, 1'b0, 64'h0);
    cyc();
    drive(mk(8'h61, 8'h45, 64'h0, 1'b1), 1'b0, 1'b0, 1'b1, 64'h0);
    #1;
    chk("err_nop_icode", 64'(bus.icode_o), 64'h1);
    chk("err_nop_rA",    64'(bus.rA_o), 64'hF);
    cyc();
    chk("stall_pc",   bus.imem_addr_o, 64'h200);
    chk("stall_stat", 64'(bus.stat_o), 64'd1);
`ifdef FETCH_ICOUNT_EN
    chk("stall_icount", bus.icount_o, 64'd7);
`endif

    // PC wrap at 2^64
    drive(mk(8'h80, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0), 1'b1, 1'b0, 1'b0, 64'h0);
    cyc();
    drive(mk(8'h30, 8'hF2, 64'h5, 1'b1), 1'b1, 1'b0, 1'b0, 64'h0);
    #1;
    chk("wrap_valP", bus.valP_o, 64'h9);
    cyc();
    chk("wrap_pc", bus.imem_addr_o, 64'h9);

    // assorted lengths: 2,10,2,2,2,10,1 from 0x9
    drive(mk(8'h26, 8'h12, 64'h0, 1'b1), 1'b1, 1'b0, 1'b0, 64'h0); cyc();
    drive(mk(8'h50, 8'h34, 64'h77, 1'b1), 1'b1, 1'b0, 1'b0, 64'h0); cyc();
    drive(mk(8'hA0, 8'h4F, 64'h0, 1'b1), 1'b1, 1'b0, 1'b0, 64'h0); cyc();
    drive(mk(8'hB0, 8'h5F, 64'h0, 1'b1), 1'b1, 1'b0, 1'b0, 64'h0); cyc();
    drive(mk(8'h63, 8'h67, 64'h0, 1'b1), 1'b1, 1'b0, 1'b0, 64'h0); cyc();
    drive(mk(8'h40, 8'h89, 64'h8, 1'b1), 1'b1, 1'b0, 1'b0, 64'h0); cyc();
    drive(mk(8'h10, 8'h00, 64'h0, 1'b0), 1'b1, 1'b0, 1'b0, 64'h0); cyc();
    chk("mix_pc", bus.imem_addr_o, 64'h26);

    // five valid steps after reset
    do_reset();
    drive(mk(8'h10, 8'h00, 64'h0, 1'b0), 1'b1, 1'b0, 1'b0, 64'h0);
    repeat (5) cyc();
    chk("five_pc", bus.imem_addr_o, 64'h5);
`ifdef FETCH_ICOUNT_EN
    chk("five_icount", bus.icount_o, 64'd5);
`endif

    // HALT is terminal
    drive(mk(8'h60, 8'h12, 64'h0, 1'b1), 1'b1, 1'b0, 1'b0, 64'h0); cyc();
    drive(mk(8'h00, 8'h00, 64'h0, 1'b0), 1'b1, 1'b0, 1'b0, 64'h0);
    #1;
    chk("halt_icode_run", 64'(bus.icode_o), 64'h0);
    cyc();
    chk("halt_stat", 64'(bus.stat_o), 64'd2);
    chk("halt_pc",   bus.imem_addr_o, 64'h7);
    chk("halt_nop",  64'(bus.icode_o), 64'h1);
    drive(mk(8'h30, 8'h12, 64'h99, 1'b1), 1'b1, 1'b0, 1'b0, 64'h0);
    cyc();
    chk("halt_frozen", bus.imem_addr_o, 64'h7);
    do_reset();
    chk("halt_rst_pc",   bus.imem_addr_o, 64'h0);
    chk("halt_rst_stat", 64'(bus.stat_o), 64'd1);

    drive(mk(8'h65, 8'h12, 64'h0, 1'b1), 1'b1, 1'b0, 1'b0, 64'h0); cyc();
    chk("ins_stat", 64'(bus.stat_o), 64'd4);
    chk("ins_pc",   bus.imem_addr_o, 64'h0);
    do_reset();
    drive(mk(8'hF0, 8'h00, 64'h0, 1'b0), 1'b1, 1'b0, 1'b1, 64'h0); cyc();
    chk("adr_stat", 64'(bus.stat_o), 64'd3);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      drive(mk(codes[i], 8'h12, 64'h40, 1'b1), 1'b1, 1'b1, 1'b0, 64'h0);
      cyc();
      chk($sformatf("code_%h_stat", codes[i]), 64'(bus.stat_o), 64'(code_stat[i]));
      do_reset();
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
